// File: rtl/uart8_pkg.sv
// Shared UART8 definitions: TX state encoding, clog2 helper and bit-period calculation.
// UART8_TX_PARITY_EN selects the optional even-parity frame in the transmitter.
package uart8_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned clks_per_bit(input int unsigned clock_rate,
                                                 input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart8_sync_fifo.sv
// Synchronous FIFO with show-ahead read data, registered full/empty/count.
module uart8_sync_fifo
    import uart8_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $fatal(1, "uart8_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart8_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO front end, baud divider and frame FSM.
// Define UART8_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart8_tx_fifo
    import uart8_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [7:0]                  in,
    input  logic                        valid,
    output logic                        ready,
    output logic                        out,
    output logic                        busy,
    output logic [clog2(FIFO_DEPTH):0]  count
);
    localparam int unsigned CPB = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned BW  = (clog2(CPB) < 1) ? 1 : clog2(CPB);

    if (CPB < 2) begin : g_cpb_chk
        $fatal(1, "uart8_tx_fifo: CLOCK_RATE/BAUD_RATE must be at least 2");
    end

    logic       fifo_full, fifo_empty, push, pop;
    logic [7:0] fifo_rdata;

    assign ready = !fifo_full;
    assign push  = valid && !fifo_full && !reset;

    uart8_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          out_q, out_d, busy_q, busy_d;
    logic          bit_end, can_start;
`ifdef UART8_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // Outputs reflect the state of the previous cycle, giving the two-edge push-to-start latency.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        out_d     = 1'b1;
        busy_d    = (state_q != IDLE);
        bit_end   = (baud_q == BW'(CPB - 1));
        can_start = !fifo_empty && en;
        baud_d    = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
`ifdef UART8_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (can_start) state_d = START;
            end
            START: begin
                out_d = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                out_d = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART8_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART8_TX_PARITY_EN
            PARITY: begin
                out_d = par_q;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = can_start ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Entering START from IDLE or STOP pops the next byte into the shifter.
        if (state_d == START && state_q != START) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            idx_d   = '0;
`ifdef UART8_TX_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART8_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
`ifdef UART8_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart8_tx_fifo.sv
// Self-checking bench for uart8_tx_fifo (CLKS_PER_BIT=10, FIFO_DEPTH=16).
module tb_uart8_tx_fifo;
    localparam int unsigned CR    = 1000;
    localparam int unsigned BR    = 100;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CPB   = 10;
`ifdef UART8_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FL = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset, en, valid, ready, out, busy;
    logic [7:0] din;
    logic [4:0] count;

    always #5 clk = ~clk;

    uart8_tx_fifo #(
        .CLOCK_RATE (CR),
        .BAUD_RATE  (BR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (din),
        .valid (valid),
        .ready (ready),
        .out   (out),
        .busy  (busy),
        .count (count)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic [9:0] line;  // {stop, data[7:0], start} as seen on the wire
        logic       par;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        valid = 1'b1;
        din   = d;
        tick();
        valid = 1'b0;
    endtask

    // Line level t cycles after the first start bit of a gapless stream of frames.
    function automatic logic model_out(input logic [7:0] q[$], input int t);
        int f;
        int b;
        f = t / int'(FL);
        b = (t % int'(FL)) / int'(CPB);
        if (f >= q.size()) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return q[f][b-1];
        if (NBITS == 11 && b == 9) return ^q[f];
        return 1'b1;
    endfunction

    // Called just after the edge at which the FSM leaves IDLE.
    task automatic check_frames(input logic [7:0] q[$]);
        int n;
        n = q.size();
        chk("out_before_start", out, 1);
        chk("busy_before_start", busy, 0);
        for (int j = 1; j <= n * int'(FL) + 2; j++) begin
            tick();
            chk("stream_out", out, model_out(q, j - 1));
            chk("stream_busy", busy, ((j - 1) < n * int'(FL)) ? 1 : 0);
        end
        chk("stream_count_end", count, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic       e;
        int         k;
        int         n;

        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
        vecs[4] = '{8'h81, 10'b1100000010, 1'b0};
        vecs[5] = '{8'h07, 10'b1000001110, 1'b1};
        vecs[6] = '{8'h80, 10'b1100000000, 1'b1};

        reset = 1'b1;
        en    = 1'b0;
        valid = 1'b0;
        din   = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_out", out, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", count, 0);
        chk("reset_ready", ready, 1);

        // Table: single frames with exact latency and bit timing.
        en = 1'b1;
        for (int v = 0; v < 7; v++) begin
            push_byte(vecs[v].d);
            chk("tbl_count_after_push", count, 1);
            chk("tbl_out_n", out, 1);
            tick();
            chk("tbl_out_n1", out, 1);
            chk("tbl_busy_n1", busy, 0);
            chk("tbl_count_n1", count, 0);
            for (int j = 1; j <= int'(FL) + 2; j++) begin
                tick();
                if (((j - 1) % int'(CPB)) == 5) begin
                    k = (j - 1) / int'(CPB);
                    if (k < 9) e = vecs[v].line[k];
                    else if (NBITS == 11 && k == 9) e = vecs[v].par;
                    else e = vecs[v].line[9];
                    chk("tbl_bit", out, e);
                end
                if (j == 1) chk("tbl_start_edge", out, 0);
                if (j - 1 == int'(FL) - 1) chk("tbl_busy_last", busy, 1);
                if (j - 1 == int'(FL)) chk("tbl_busy_fall", busy, 0);
            end
        end

        // Back-to-back: second start immediately follows first stop; push and pop coincide.
        valid = 1'b1;
        din   = 8'h00;
        tick();
        din = 8'hFF;
        tick();
        valid = 1'b0;
        chk("b2b_count_pushpop", count, 1);
        q = {8'h00, 8'hFF};
        check_frames(q);

        // Full: 17 writes with en low, 17th dropped, pop while full admits no push.
        en = 1'b0;
        q = {};
        for (int i = 0; i < 17; i++) begin
            valid = 1'b1;
            din   = 8'(i * 13 + 7);
            if (i < 16) q.push_back(din);
            chk("full_ready_before", ready, (i < 16) ? 1 : 0);
            tick();
            chk("full_count", count, (i < 16) ? i + 1 : 16);
        end
        chk("full_ready", ready, 0);
        din = 8'hEE;
        en  = 1'b1;
        tick();
        valid = 1'b0;
        chk("full_pop_no_push", count, 15);
        check_frames(q);

        // Enable gating: drop en during 0x3C data bits; 0x81 waits until en returns.
        push_byte(8'h3C);
        push_byte(8'h81);
        q = {8'h3C};
        for (int j = 1; j <= int'(FL) + 150; j++) begin
            tick();
            chk("gate_out", out, model_out(q, j - 1));
            chk("gate_busy", busy, ((j - 1) < int'(FL)) ? 1 : 0);
            if (j == 30) en = 1'b0;
        end
        chk("gate_count_held", count, 1);
        en = 1'b1;
        tick();
        q = {8'h81};
        check_frames(q);

        // Reset during bit 4 of 0x55 with three bytes queued behind it.
        push_byte(8'h55);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        repeat (53) tick();
        chk("rst_mid_bit4", out, 1);
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_count", count, 3);
        reset = 1'b1;
        valid = 1'b1;
        din   = 8'h99;
        tick();
        reset = 1'b0;
        valid = 1'b0;
        chk("rst_out", out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", ready, 1);
        for (int j = 0; j < 250; j++) begin
            tick();
            chk("rst_quiet_out", out, 1);
            chk("rst_quiet_busy", busy, 0);
        end
        chk("rst_quiet_count", count, 0);

        // Randomised bursts against the stream model.
        for (int it = 0; it < 8; it++) begin
            en = 1'b0;
            n  = int'($urandom_range(1, 4));
            q  = {};
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                push_byte(q[i]);
            end
            chk("rnd_count", count, n);
            repeat ($urandom_range(0, 5)) tick();
            en = 1'b1;
            tick();
            check_frames(q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
